// File: rtl/uart_hex_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_tx_if
// Description : Handshake bundle for the hex console formatter.
//               Host side : start, value (in)   busy, done (out)
//               UART side : tx_rdy (in)          tx_en, tx_data (out)
//               "master" is the formatter's view, "slave" is the view of the
//               host/UART pair that surrounds it.
// Parameters  : DIGITS - number of hex digits; value is 4*DIGITS bits wide.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_hex_tx_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   value;
  logic                  busy;
  logic                  done;
  logic                  tx_en;
  logic [7:0]            tx_data;
  logic                  tx_rdy;

  modport master (
    input  start, value, tx_rdy,
    output busy, done, tx_en, tx_data
  );

  modport slave (
    output start, value, tx_rdy,
    input  busy, done, tx_en, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_hex_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_tx
// Description : Latches a binary value on start and hands it to the UART one
//               byte at a time as uppercase ASCII hex (MS nibble first),
//               followed by CR LF. Runs on the UART baud clock and follows
//               the UART tx_en/tx_rdy handshake.
// Ports       : tx_clk - baud-rate clock shared with the UART transmitter
//               rst    - asynchronous, active-high reset
//               bus    - uart_hex_tx_if.master (start/value/busy/done to the
//                        host, tx_en/tx_data/tx_rdy to the UART)
// Options     : define UART_HEX_TX_PREFIX_EN to send "0x" before the digits.
// Parameters  : DIGITS - hex digits per value, 1..8
// Revision    : 1.0 - initial release
// ============================================================================
module uart_hex_tx #(
  parameter int DIGITS = 4
) (
  input  logic           tx_clk,
  input  logic           rst,
  uart_hex_tx_if.master  bus
);

  localparam int W = 4 * DIGITS;

`ifdef UART_HEX_TX_PREFIX_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 0;
`endif

  // Character slots: [prefix] digits CR LF. LAST_IDX is the index value
  // reached once the LF has been accepted.
  localparam logic [3:0] CR_IDX   = 4'(PRE + DIGITS);
  localparam logic [3:0] LF_IDX   = 4'(PRE + DIGITS + 1);
  localparam logic [3:0] LAST_IDX = 4'(PRE + DIGITS + 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]   r_state;
  logic [3:0]   r_idx;
  logic [W-1:0] r_shreg;
  logic         r_tx_en;
  logic [7:0]   r_tx_data;
  logic         r_busy;
  logic         r_done;
  logic         w_in_prefix;

  // Byte for a character slot; nib is the nibble currently at the top of
  // the shift register and is only used for digit slots.
  function automatic logic [7:0] char_at(input logic [3:0] idx,
                                         input logic [3:0] nib);
    logic [7:0] c;
    if (idx == CR_IDX)
      c = 8'h0D;
    else if (idx == LF_IDX)
      c = 8'h0A;
`ifdef UART_HEX_TX_PREFIX_EN
    else if (idx == 4'd0)
      c = 8'h30;
    else if (idx == 4'd1)
      c = 8'h78;
`endif
    else if (nib < 4'd10)
      c = 8'h30 + {4'd0, nib};
    else
      c = 8'h37 + {4'd0, nib};   // 'A' - 10
    return c;
  endfunction

  // Prefix characters must not consume a nibble, otherwise the first digit
  // would be lost before it is sent.
`ifdef UART_HEX_TX_PREFIX_EN
  assign w_in_prefix = (r_idx < 4'd2);
`else
  assign w_in_prefix = 1'b0;
`endif

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= 4'd0;
      r_shreg   <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shreg   <= bus.value;
            r_idx     <= 4'd0;
            r_busy    <= 1'b1;
            r_tx_data <= char_at(4'd0, bus.value[W-1 -: 4]);
            r_tx_en   <= 1'b1;
            r_state   <= SEND;
          end
        end
        SEND: begin
          // tx_en/tx_data stay put until the UART takes the byte.
          if (bus.tx_rdy) begin
            r_tx_en <= 1'b0;
            r_idx   <= r_idx + 4'd1;
            if (!w_in_prefix)
              r_shreg <= r_shreg << 4;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.tx_rdy) begin
            if (r_idx == LAST_IDX) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_idx   <= 4'd0;
              r_state <= IDLE;
            end else begin
              r_tx_data <= char_at(r_idx, r_shreg[W-1 -: 4]);
              r_tx_en   <= 1'b1;
              r_state   <= SEND;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx_en   = r_tx_en;
  assign bus.tx_data = r_tx_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_hex_tx
// Description : Directed self-checking bench for uart_hex_tx (DIGITS=4).
//               Contains a UART model that is busy for 9 edges after each
//               accepted byte, and logs every accepted byte with its edge.
//               Honours UART_HEX_TX_PREFIX_EN for the expected sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_hex_tx;
  localparam int DIGITS = 4;
`ifdef UART_HEX_TX_PREFIX_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 0;
`endif
  localparam int N     = DIGITS + PRE + 2;
  localparam int PITCH = 11;

  logic tx_clk = 1'b0;
  logic rst    = 1'b1;

  uart_hex_tx_if #(.DIGITS(DIGITS)) bus ();

  uart_hex_tx #(.DIGITS(DIGITS)) dut (
    .tx_clk (tx_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 tx_clk = ~tx_clk;

  // Edge counter: after posedge k and before posedge k+1, cyc == k.
  int cyc = 0;
  always @(posedge tx_clk) cyc <= cyc + 1;

  // UART model
  logic       rdy_q    = 1'b1;
  logic       hold     = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] bytes   [0:255];
  int         acc_cyc [0:255];
  int         nbytes   = 0;

  assign bus.tx_rdy = rdy_q & ~hold;

  always @(posedge tx_clk) begin
    if (bus.tx_en && bus.tx_rdy) begin
      if (nbytes < 256) begin
        bytes[nbytes]   <= bus.tx_data;
        acc_cyc[nbytes] <= cyc + 1;
        nbytes          <= nbytes + 1;
      end
      rdy_q    <= 1'b0;
      busy_cnt <= 9;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) rdy_q <= 1'b1;
    end
  end

  // done monitor: the pre-edge value seen at posedge k was set at edge k-1.
  int   done_cnt  = 0;
  int   done_cyc  = 0;
  logic done_busy = 1'b0;
  always @(posedge tx_clk) begin
    if (bus.done) begin
      done_cnt  <= done_cnt + 1;
      done_cyc  <= cyc;
      done_busy <= bus.busy;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int e0;

  task automatic do_start(input logic [15:0] v);
    @(negedge tx_clk);
    bus.value = v;
    bus.start = 1'b1;
    e0 = cyc + 1;
    @(negedge tx_clk);
    bus.start = 1'b0;
  endtask

  // Leaves the caller on the negedge where done is high.
  task automatic wait_done(input string tag);
    int t = 0;
    while (bus.done !== 1'b1 && t < 2000) begin
      @(negedge tx_clk);
      t++;
    end
    check(tag, 32'(bus.done), 32'd1);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge tx_clk);
  endtask

  task automatic check_seq(input string tag, input int base,
                           input logic [7:0] d3, input logic [7:0] d2,
                           input logic [7:0] d1, input logic [7:0] d0);
    logic [7:0] exp [0:11];
    int k = 0;
`ifdef UART_HEX_TX_PREFIX_EN
    exp[0] = 8'h30;
    exp[1] = 8'h78;
    k = 2;
`endif
    exp[k]   = d3;
    exp[k+1] = d2;
    exp[k+2] = d1;
    exp[k+3] = d0;
    exp[k+4] = 8'h0D;
    exp[k+5] = 8'h0A;
    check({tag, "_count"}, 32'(nbytes - base), 32'(N));
    for (int i = 0; i < N; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(bytes[base+i]), 32'(exp[i]));
  endtask

  task automatic check_pitch(input string tag, input int base);
    for (int i = 1; i < N; i++)
      check($sformatf("%s_pitch%0d", tag, i),
            32'(acc_cyc[base+i] - acc_cyc[base+i-1]), 32'(PITCH));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base2;
    int dc;
    int e0b;
    int t;
    logic [7:0] first_char;

`ifdef UART_HEX_TX_PREFIX_EN
    first_char = 8'h30;
`else
    first_char = 8'h31;
`endif

    bus.start = 1'b0;
    bus.value = '0;

    // ---- reset values ----
    @(negedge tx_clk);
    check("rst_tx_en",   32'(bus.tx_en),   32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    rst = 1'b0;
    settle(2);

    // ---- 1A2F with an always-ready UART ----
    base = nbytes;
    dc   = done_cnt;
    do_start(16'h1A2F);
    check("t1_busy_after_start", 32'(bus.busy), 32'd1);
    wait_done("t1_done");
    settle(2);
    check_seq("t1", base, 8'h31, 8'h41, 8'h32, 8'h46);
    check_pitch("t1", base);
    check("t1_first_latency", 32'(acc_cyc[base] - e0), 32'd1);
    check("t1_done_latency", 32'(done_cyc - e0), 32'(PITCH * N));
    check("t1_done_pulses", 32'(done_cnt - dc), 32'd1);
    check("t1_busy_at_done", 32'(done_busy), 32'd0);
    check("t1_busy_after", 32'(bus.busy), 32'd0);
    check("t1_tx_en_after", 32'(bus.tx_en), 32'd0);

    // ---- 0000 then FFFF, nothing in between ----
    base = nbytes;
    do_start(16'h0000);
    wait_done("t2a_done");
    settle(20);
    check_seq("t2a", base, 8'h30, 8'h30, 8'h30, 8'h30);
    check("t2_no_stray", 32'(nbytes - base), 32'(N));
    base = nbytes;
    do_start(16'hFFFF);
    wait_done("t2b_done");
    settle(2);
    check_seq("t2b", base, 8'h46, 8'h46, 8'h46, 8'h46);

    // ---- UART stalls for 40 cycles before the first acceptance ----
    @(negedge tx_clk);
    hold = 1'b1;
    base = nbytes;
    do_start(16'h1A2F);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("t3_hold_tx_en%0d", i), 32'(bus.tx_en), 32'd1);
      check($sformatf("t3_hold_data%0d", i), 32'(bus.tx_data), 32'(first_char));
      @(negedge tx_clk);
    end
    check("t3_none_during_hold", 32'(nbytes - base), 32'd0);
    hold = 1'b0;
    settle(3);
    check("t3_one_after_release", 32'(nbytes - base), 32'd1);
    check("t3_tx_en_dropped", 32'(bus.tx_en), 32'd0);
    wait_done("t3_done");
    settle(2);
    check_seq("t3", base, 8'h31, 8'h41, 8'h32, 8'h46);

    // ---- start mid-sequence is ignored; start right after done is taken ----
    base = nbytes;
    do_start(16'h1A2F);
    t = 0;
    while (nbytes < base + 2 && t < 500) begin
      @(negedge tx_clk);
      t++;
    end
    check("t4_reached_mid", 32'(nbytes >= base + 2), 32'd1);
    bus.value = 16'h0000;
    bus.start = 1'b1;
    @(negedge tx_clk);
    bus.start = 1'b0;
    bus.value = 16'h5555;
    wait_done("t4a_done");
    // done is high now: issue the next start in this cycle.
    base2     = nbytes;
    bus.value = 16'hBEEF;
    bus.start = 1'b1;
    e0b       = cyc + 1;
    @(negedge tx_clk);
    bus.start = 1'b0;
    check_seq("t4a", base, 8'h31, 8'h41, 8'h32, 8'h46);
    check("t4b_busy_accepted", 32'(bus.busy), 32'd1);
    check("t4b_tx_en_accepted", 32'(bus.tx_en), 32'd1);
    wait_done("t4b_done");
    settle(2);
    check_seq("t4b", base2, 8'h42, 8'h45, 8'h45, 8'h46);
    check("t4b_done_latency", 32'(done_cyc - e0b), 32'(PITCH * N));

    // ---- asynchronous reset after the third byte ----
    base = nbytes;
    do_start(16'h1A2F);
    t = 0;
    while (!(nbytes == base + 3 && bus.tx_en === 1'b1) && t < 500) begin
      @(negedge tx_clk);
      t++;
    end
    check("t5_reached_byte4", 32'(bus.tx_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_tx_en",   32'(bus.tx_en),   32'd0);
    check("t5_async_tx_data", 32'(bus.tx_data), 32'h00);
    check("t5_async_busy",    32'(bus.busy),    32'd0);
    check("t5_async_done",    32'(bus.done),    32'd0);
    settle(3);
    rst = 1'b0;
    settle(3);
    check("t5_discarded", 32'(nbytes - base), 32'd3);
    base = nbytes;
    do_start(16'h1A2F);
    wait_done("t5_done");
    settle(2);
    check_seq("t5", base, 8'h31, 8'h41, 8'h32, 8'h46);
    check("t5_done_latency", 32'(done_cyc - e0), 32'(PITCH * N));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
